// File: rtl/ps2_led_sequencer.sv
// Host-side PS/2 keyboard command sequencer: reset/BAT handshake, lock-LED updates
// with ACK/resend/timeout retry, and removal of consumed response bytes from the stream.
module ps2_led_sequencer #(
    parameter int ACK_TIMEOUT   = 1000000,
    parameter int BAT_TIMEOUT   = 50000000,
    parameter int MAX_RETRY     = 3,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [2:0] led_state,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    output logic [7:0] the_command,
    output logic       send_command,
    output logic [7:0] data_out,
    output logic       data_out_en,
    output logic [2:0] led_applied,
    output logic       busy,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_SEND,
        S_INIT_ACK,
        S_INIT_BAT,
        S_ED_SEND,
        S_ED_ACK,
        S_LED_SEND,
        S_LED_ACK
    } state_e;

    localparam int TMAX = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int AW   = $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] ACK_LIMIT   = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] BAT_LIMIT   = TW'(BAT_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_MAX   = '1;
    localparam logic [AW-1:0] RETRY_LIMIT = AW'(MAX_RETRY);
    localparam logic [AW-1:0] FIRST_TRY   = AW'(1);

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LED  = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [AW-1:0]   attempt_q, attempt_d;
    logic            send_q, send_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      data_q, data_d;
    logic            data_en_q, data_en_d;
    logic [2:0]      led_applied_q, led_applied_d;
    logic [2:0]      led_attempt_q, led_attempt_d;
    logic            error_q, error_d;

    state_e          eff_state;
    logic [TW-1:0]   timer_cur;
    logic            sent_now;
    logic            tx_fail;
    logic            in_wait;
    logic            is_rsp;
    logic            rx_ack;
    logic            fail;

    function automatic logic is_send(input state_e s);
        return (s == S_INIT_SEND) || (s == S_ED_SEND) || (s == S_LED_SEND);
    endfunction

    // Every failure path retransmits the byte that the failing state belongs to.
    function automatic state_e send_of(input state_e s);
        case (s)
            S_INIT_SEND, S_INIT_ACK, S_INIT_BAT: return S_INIT_SEND;
            S_ED_SEND, S_ED_ACK:                 return S_ED_SEND;
            S_LED_SEND, S_LED_ACK:               return S_LED_SEND;
            default:                             return S_IDLE;
        endcase
    endfunction

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        attempt_d     = attempt_q;
        cmd_d         = cmd_q;
        data_d        = data_q;
        data_en_d     = 1'b0;
        led_applied_d = led_applied_q;
        led_attempt_d = led_attempt_q;
        error_d       = error_q;
        fail          = 1'b0;

        sent_now = send_q && command_was_sent;
        tx_fail  = send_q && error_communication_timed_out && !command_was_sent;

        // A byte arriving with the send strobe is judged by the ACK state being entered.
        eff_state = state_q;
        if (sent_now) begin
            case (state_q)
                S_INIT_SEND: eff_state = S_INIT_ACK;
                S_ED_SEND:   eff_state = S_ED_ACK;
                S_LED_SEND:  eff_state = S_LED_ACK;
                default:     eff_state = state_q;
            endcase
        end
        timer_cur = (eff_state != state_q) ? '0 : timer_q;

        in_wait = (eff_state == S_INIT_ACK) || (eff_state == S_INIT_BAT) ||
                  (eff_state == S_ED_ACK)   || (eff_state == S_LED_ACK);
        is_rsp  = (received_data == RSP_ACK)    || (received_data == RSP_RESEND) ||
                  (received_data == RSP_BAT_OK) || (received_data == RSP_BAT_FAIL);
        rx_ack  = received_data_en && (received_data == RSP_ACK);

        if (received_data_en && !(in_wait && is_rsp)) begin
            data_d    = received_data;
            data_en_d = 1'b1;
        end

        state_d = eff_state;
        case (eff_state)
            S_IDLE: begin
                if ((led_state != led_applied_q) &&
                    !(error_q && (led_state == led_attempt_q))) begin
                    state_d       = S_ED_SEND;
                    led_attempt_d = led_state;
                    attempt_d     = FIRST_TRY;
                end
            end
            S_INIT_SEND, S_ED_SEND, S_LED_SEND: begin
                fail = tx_fail;
            end
            S_INIT_ACK, S_ED_ACK, S_LED_ACK: begin
                timer_d = (timer_cur == TIMER_MAX) ? timer_cur : timer_cur + TW'(1);
                if (rx_ack) begin
                    case (eff_state)
                        S_INIT_ACK: begin
                            state_d = S_INIT_BAT;
                            timer_d = '0;
                        end
                        S_ED_ACK: begin
                            state_d   = S_LED_SEND;
                            attempt_d = FIRST_TRY;
                        end
                        default: begin
                            state_d       = S_IDLE;
                            led_applied_d = led_attempt_q;
                            error_d       = 1'b0;
                        end
                    endcase
                end else if ((received_data_en && (received_data == RSP_RESEND)) ||
                             (timer_cur == ACK_LIMIT)) begin
                    fail = 1'b1;
                end
            end
            S_INIT_BAT: begin
                timer_d = (timer_cur == TIMER_MAX) ? timer_cur : timer_cur + TW'(1);
                if (received_data_en && (received_data == RSP_BAT_OK)) begin
                    state_d = S_IDLE;
                end else if ((received_data_en && (received_data == RSP_BAT_FAIL)) ||
                             (timer_cur == BAT_LIMIT)) begin
                    fail = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            if (attempt_q < RETRY_LIMIT) begin
                attempt_d = attempt_q + AW'(1);
                state_d   = send_of(eff_state);
            end else begin
                error_d = 1'b1;
                state_d = S_IDLE;
            end
        end

        // Any strobe forces one low cycle on the request before a retransmission.
        send_d = is_send(state_d) &&
                 !(send_q && (command_was_sent || error_communication_timed_out));

        case (state_d)
            S_INIT_SEND: cmd_d = CMD_RESET;
            S_ED_SEND:   cmd_d = CMD_SET_LED;
            S_LED_SEND:  cmd_d = {5'b0, led_attempt_d};
            default:     cmd_d = cmd_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= INIT_ON_RESET ? S_INIT_SEND : S_IDLE;
            timer_q       <= '0;
            attempt_q     <= FIRST_TRY;
            send_q        <= 1'b0;
            cmd_q         <= 8'h00;
            data_q        <= 8'h00;
            data_en_q     <= 1'b0;
            led_applied_q <= 3'b000;
            led_attempt_q <= 3'b000;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            attempt_q     <= attempt_d;
            send_q        <= send_d;
            cmd_q         <= cmd_d;
            data_q        <= data_d;
            data_en_q     <= data_en_d;
            led_applied_q <= led_applied_d;
            led_attempt_q <= led_attempt_d;
            error_q       <= error_d;
        end
    end

    assign the_command  = cmd_q;
    assign send_command = send_q;
    assign data_out     = data_q;
    assign data_out_en  = data_en_q;
    assign led_applied  = led_applied_q;
    assign busy         = (state_q != S_IDLE);
    assign error        = error_q;

endmodule

// File: tb/tb_ps2_led_sequencer.sv
// Directed-sequence bench with randomized masks and scan codes; expectations come from
// a protocol-level model of applied LEDs, error flag, transmitted bytes and forwarded bytes.
module tb_ps2_led_sequencer;

    localparam int ACK_TO  = 100;
    localparam int BAT_TO  = 300;
    localparam int RETRIES = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] led_state;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic [7:0] the_command;
    logic       send_command;
    logic [7:0] data_out;
    logic       data_out_en;
    logic [2:0] led_applied;
    logic       busy;
    logic       error;

    always #5 clk = ~clk;

    ps2_led_sequencer #(
        .ACK_TIMEOUT  (ACK_TO),
        .BAT_TIMEOUT  (BAT_TO),
        .MAX_RETRY    (RETRIES),
        .INIT_ON_RESET(1'b1)
    ) dut (
        .CLOCK_50                     (clk),
        .reset                        (reset),
        .led_state                    (led_state),
        .received_data                (received_data),
        .received_data_en             (received_data_en),
        .command_was_sent             (command_was_sent),
        .error_communication_timed_out(error_communication_timed_out),
        .the_command                  (the_command),
        .send_command                 (send_command),
        .data_out                     (data_out),
        .data_out_en                  (data_out_en),
        .led_applied                  (led_applied),
        .busy                         (busy),
        .error                        (error)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_log[$];
    logic [7:0] fwd_log[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_fwd[$];

    logic [2:0] exp_applied;
    logic [2:0] exp_attempt;
    logic       exp_error;

    // Observers sample shortly after the active edge, well before the negedge checks.
    logic prev_send = 1'b0;
    always begin
        @(posedge clk);
        #2;
        if (send_command && !prev_send) tx_log.push_back(the_command);
        prev_send = send_command;
        if (data_out_en) fwd_log.push_back(data_out);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_send(input string tag, input logic [7:0] exp_b);
        for (int i = 0; i < 400; i++) begin
            if (send_command) break;
            @(negedge clk);
        end
        exp_tx.push_back(exp_b);
        check({tag, "_send"}, {31'b0, send_command}, 32'd1);
        check({tag, "_cmd"}, {24'b0, the_command}, {24'b0, exp_b});
    endtask

    task automatic pulse_sent();
        command_was_sent = 1'b1;
        @(negedge clk);
        command_was_sent = 1'b0;
    endtask

    task automatic pulse_err();
        error_communication_timed_out = 1'b1;
        @(negedge clk);
        error_communication_timed_out = 1'b0;
    endtask

    function automatic bit is_response(input logic [7:0] b);
        return (b == 8'hFA) || (b == 8'hFE) || (b == 8'hAA) || (b == 8'hFC);
    endfunction

    // in_wait tells the model whether the sequencer is waiting on a keyboard response.
    task automatic rx(input logic [7:0] b, input bit in_wait);
        received_data    = b;
        received_data_en = 1'b1;
        if (!(in_wait && is_response(b))) exp_fwd.push_back(b);
        @(negedge clk);
        received_data_en = 1'b0;
    endtask

    task automatic sent_with_rx(input logic [7:0] b);
        command_was_sent = 1'b1;
        received_data    = b;
        received_data_en = 1'b1;
        if (!is_response(b)) exp_fwd.push_back(b);
        @(negedge clk);
        command_was_sent = 1'b0;
        received_data_en = 1'b0;
    endtask

    function automatic bit should_start(input logic [2:0] m);
        return (m != exp_applied) && !(exp_error && (m == exp_attempt));
    endfunction

    function automatic logic [2:0] rand_mask();
        logic [2:0] m;
        do m = 3'($urandom_range(0, 7)); while (!should_start(m));
        return m;
    endfunction

    function automatic logic [7:0] rand_scan();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (is_response(b));
        return b;
    endfunction

    task automatic check_idle_state(input string tag);
        check({tag, "_applied"}, {29'b0, led_applied}, {29'b0, exp_applied});
        check({tag, "_error"}, {31'b0, error}, {31'b0, exp_error});
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic led_sequence(input string tag, input logic [2:0] m);
        led_state   = m;
        exp_attempt = m;
        wait_send({tag, "_ed"}, 8'hED);
        pulse_sent();
        rx(8'hFA, 1'b1);
        wait_send({tag, "_mask"}, {5'b0, m});
        pulse_sent();
        rx(8'hFA, 1'b1);
        exp_applied = m;
        exp_error   = 1'b0;
        check_idle_state(tag);
    endtask

    initial begin
        logic [7:0] b;
        logic [2:0] m;
        logic [2:0] m2;

        reset = 1'b1;
        led_state = 3'b000;
        received_data = 8'h00;
        received_data_en = 1'b0;
        command_was_sent = 1'b0;
        error_communication_timed_out = 1'b0;
        exp_applied = 3'b000;
        exp_attempt = 3'b000;
        exp_error   = 1'b0;
        step(3);

        check("rst_send", {31'b0, send_command}, 32'd0);
        check("rst_cmd", {24'b0, the_command}, 32'h00);
        check("rst_dout", {24'b0, data_out}, 32'h00);
        check("rst_dout_en", {31'b0, data_out_en}, 32'd0);
        check("rst_applied", {29'b0, led_applied}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd1);

        // Power-on handshake
        reset = 1'b0;
        wait_send("init", 8'hFF);
        pulse_sent();
        rx(8'hFA, 1'b1);
        rx(8'hAA, 1'b1);
        check_idle_state("init");
        step(2);
        check("init_no_fwd", fwd_log.size(), exp_fwd.size());

        led_sequence("led100", 3'b100);

        // Scan codes and response-valued bytes outside ACK waits are forwarded.
        b = rand_scan();
        rx(b, 1'b0);
        check("idle_fwd_en", {31'b0, data_out_en}, 32'd1);
        check("idle_fwd_data", {24'b0, data_out}, {24'b0, b});
        rx(8'hFA, 1'b0);
        check("idle_fa_fwd", {24'b0, data_out}, 32'hFA);

        // Controller failure, then resend, then success on the final permitted attempt.
        m = rand_mask();
        led_state   = m;
        exp_attempt = m;
        wait_send("rs1", 8'hED);
        pulse_err();
        check("rs_gap", {31'b0, send_command}, 32'd0);
        wait_send("rs2", 8'hED);
        pulse_sent();
        rx(8'hFE, 1'b1);
        wait_send("rs3", 8'hED);
        pulse_sent();
        rx(8'hFA, 1'b1);
        wait_send("rs_mask", {5'b0, m});
        pulse_sent();
        rx(8'hFA, 1'b1);
        exp_applied = m;
        exp_error   = 1'b0;
        check_idle_state("rs");

        // ACK arriving in the same cycle as the sent strobe.
        m = rand_mask();
        led_state   = m;
        exp_attempt = m;
        wait_send("sim_ed", 8'hED);
        sent_with_rx(8'hFA);
        wait_send("sim_mask", {5'b0, m});
        pulse_sent();
        rx(8'hFA, 1'b1);
        exp_applied = m;
        check_idle_state("sim");

        // Scan code during LED_ACK; led_state changed mid-sequence is applied afterwards.
        m = rand_mask();
        led_state   = m;
        exp_attempt = m;
        wait_send("il_ed", 8'hED);
        pulse_sent();
        do m2 = 3'($urandom_range(0, 7)); while (m2 == m);
        led_state = m2;
        rx(8'hFA, 1'b1);
        wait_send("il_mask", {5'b0, m});
        pulse_sent();
        b = rand_scan();
        rx(b, 1'b1);
        check("il_fwd_en", {31'b0, data_out_en}, 32'd1);
        check("il_fwd_data", {24'b0, data_out}, {24'b0, b});
        rx(8'hFA, 1'b1);
        check("il_fa_dropped", {31'b0, data_out_en}, 32'd0);
        exp_applied = m;
        check("il_applied", {29'b0, led_applied}, {29'b0, m});
        led_sequence("il_next", m2);

        // No responses at all: three transmissions, then sticky error.
        m = rand_mask();
        led_state   = m;
        exp_attempt = m;
        for (int a = 0; a < RETRIES; a++) begin
            wait_send("to_ed", 8'hED);
            pulse_sent();
        end
        step(ACK_TO + 20);
        exp_error = 1'b1;
        check_idle_state("to");
        step(300);
        check("to_no_restart", tx_log.size(), exp_tx.size());
        check("to_send_low", {31'b0, send_command}, 32'd0);
        m2 = rand_mask();
        led_sequence("to_recover", m2);

        // Reset while a request is pending, then a BAT failure followed by a clean init.
        m = rand_mask();
        led_state   = m;
        exp_attempt = m;
        wait_send("mr_ed", 8'hED);
        reset = 1'b1;
        step(1);
        check("mr_send", {31'b0, send_command}, 32'd0);
        check("mr_applied", {29'b0, led_applied}, 32'd0);
        check("mr_error", {31'b0, error}, 32'd0);
        step(2);
        reset = 1'b0;
        exp_applied = 3'b000;
        exp_error   = 1'b0;
        wait_send("mr_init1", 8'hFF);
        pulse_sent();
        rx(8'hFA, 1'b1);
        rx(8'hFC, 1'b1);
        wait_send("mr_init2", 8'hFF);
        pulse_sent();
        rx(8'hFA, 1'b1);
        rx(8'hAA, 1'b1);
        led_sequence("mr_led", m);

        step(5);
        check("tx_count", tx_log.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            check($sformatf("tx_%0d", i), {24'b0, tx_log[i]}, {24'b0, exp_tx[i]});
        check("fwd_count", fwd_log.size(), exp_fwd.size());
        for (int i = 0; i < exp_fwd.size() && i < fwd_log.size(); i++)
            check($sformatf("fwd_%0d", i), {24'b0, fwd_log[i]}, {24'b0, exp_fwd[i]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
